// File: rtl/formula_chk_pkg.sv
// Shared types for the formula result checker: error codes,
// checker FSM states and counter width.
package formula_chk_pkg;

    // Error code reported on err_code; only the first error is kept.
    typedef enum logic [1:0] {
        ERR_NONE       = 2'd0,
        ERR_MISMATCH   = 2'd1,
        ERR_UNEXPECTED = 2'd2,
        ERR_OVERFLOW   = 2'd3
    } err_code_t;

    // Checker state: RUN until the first error, then FAIL until rst.
    typedef enum logic {
        ST_RUN  = 1'b0,
        ST_FAIL = 1'b1
    } state_t;

    localparam int CNT_W = 33;

endpackage

// File: rtl/formula_chk_fifo.sv
// In-order queue of expected results awaiting a DUT result.
// Ports: clk, rst (sync, active-high), push/din write the tail,
// pop advances the head, dout shows the head, pending/full/empty
// give occupancy. Storage is not reset; only pointers and count are.
module formula_chk_fifo #(
    parameter int WIDTH = 32,
    parameter int DEPTH = 16
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     push,
    input  logic                     pop,
    input  logic [WIDTH-1:0]         din,
    output logic [WIDTH-1:0]         dout,
    output logic [$clog2(DEPTH):0]   pending,
    output logic                     full,
    output logic                     empty
);

    localparam int AW = $clog2(DEPTH);
    localparam int PW = AW + 1;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;

    // Pointers wrap naturally; occupancy alone tells full from empty.
    assign full  = (pending == PW'(DEPTH));
    assign empty = (pending == '0);
    assign dout  = mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr  <= '0;
            rd_ptr  <= '0;
            pending <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + AW'(1);
            if (pop)  rd_ptr <= rd_ptr + AW'(1);
            case ({push, pop})
                2'b10:   pending <= pending + PW'(1);
                2'b01:   pending <= pending - PW'(1);
                default: pending <= pending;
            endcase
        end
    end

    // Push at full with a same-cycle pop overwrites the head slot
    // only after it has been read for this cycle's compare.
    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr] <= din;
    end

endmodule

// File: rtl/formula_res_checker.sv
// Scoreboard checker: queues expected results and compares DUT results in order.
// Ports: clk, rst, exp_vld/exp, res_vld/res in; pending, fail, err_code,
// err_expected, err_actual, arg_cnt, res_cnt, n_cycles, pass out.
module formula_res_checker
    import formula_chk_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int DEPTH = 16
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   exp_vld,
    input  logic [WIDTH-1:0]       exp,
    input  logic                   res_vld,
    input  logic [WIDTH-1:0]       res,
    output logic [$clog2(DEPTH):0] pending,
    output logic                   fail,
    output logic [1:0]             err_code,
    output logic [WIDTH-1:0]       err_expected,
    output logic [WIDTH-1:0]       err_actual,
    output logic [CNT_W-1:0]       arg_cnt,
    output logic [CNT_W-1:0]       res_cnt,
    output logic [CNT_W-1:0]       n_cycles,
    output logic                   pass
);

    state_t           state;
    logic             run;
    logic             full;
    logic             empty;
    logic [WIDTH-1:0] head;
    logic             bypass;
    logic             do_push;
    logic             do_pop;
    logic             overflow;
    logic             unexpected;
    logic             mismatch;
    logic [WIDTH-1:0] cmp_val;
    err_code_t        err_nxt;

    assign run  = (state == ST_RUN);
    assign pass = !fail && (pending == '0);

    formula_chk_fifo #(
        .WIDTH (WIDTH),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk     (clk),
        .rst     (rst),
        .push    (do_push),
        .pop     (do_pop),
        .din     (exp),
        .dout    (head),
        .pending (pending),
        .full    (full),
        .empty   (empty)
    );

    always_comb begin
        // With nothing queued, a result arriving alongside its expected
        // value is checked directly and never enters the queue.
        bypass     = run && exp_vld && res_vld && empty;
        do_pop     = run && res_vld && !empty;
        // At full, a push is only legal when the head leaves this cycle.
        do_push    = run && exp_vld && !bypass && (!full || res_vld);
        overflow   = run && exp_vld && !res_vld && full;
        unexpected = run && res_vld && !exp_vld && empty;
        cmp_val    = bypass ? exp : head;
        // Case inequality so X/Z on res is treated as a mismatch.
        mismatch   = run && res_vld && !unexpected && (res !== cmp_val);

        err_nxt = ERR_NONE;
        if (overflow)
            err_nxt = ERR_OVERFLOW;
        else if (unexpected)
            err_nxt = ERR_UNEXPECTED;
        else if (mismatch)
            err_nxt = ERR_MISMATCH;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state        <= ST_RUN;
            fail         <= 1'b0;
            err_code     <= ERR_NONE;
            err_expected <= '0;
            err_actual   <= '0;
            arg_cnt      <= '0;
            res_cnt      <= '0;
            n_cycles     <= '0;
        end else begin
            case (state)
                ST_RUN: begin
                    n_cycles <= n_cycles + CNT_W'(1);
                    if (exp_vld) arg_cnt <= arg_cnt + CNT_W'(1);
                    if (res_vld) res_cnt <= res_cnt + CNT_W'(1);
                    if (err_nxt != ERR_NONE) begin
                        state    <= ST_FAIL;
                        fail     <= 1'b1;
                        err_code <= err_nxt;
                        if (err_nxt == ERR_MISMATCH) begin
                            err_expected <= cmp_val;
                            err_actual   <= res;
                        end
                    end
                end
                ST_FAIL: begin
                    state <= ST_FAIL;
                end
                default: begin
                    state <= ST_FAIL;
                    fail  <= 1'b1;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_formula_res_checker.sv
// Testbench for formula_res_checker: reference model feeds a scoreboard of
// expected output snapshots, popped and compared after each clock edge.
module tb_formula_res_checker;

    localparam int WIDTH = 32;
    localparam int DEPTH = 16;
    localparam int PW    = $clog2(DEPTH) + 1;

    logic             clk = 1'b0;
    logic             rst;
    logic             exp_vld;
    logic [WIDTH-1:0] exp;
    logic             res_vld;
    logic [WIDTH-1:0] res;
    logic [PW-1:0]    pending;
    logic             fail;
    logic [1:0]       err_code;
    logic [WIDTH-1:0] err_expected;
    logic [WIDTH-1:0] err_actual;
    logic [32:0]      arg_cnt;
    logic [32:0]      res_cnt;
    logic [32:0]      n_cycles;
    logic             pass;

    formula_res_checker #(
        .WIDTH (WIDTH),
        .DEPTH (DEPTH)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .exp_vld      (exp_vld),
        .exp          (exp),
        .res_vld      (res_vld),
        .res          (res),
        .pending      (pending),
        .fail         (fail),
        .err_code     (err_code),
        .err_expected (err_expected),
        .err_actual   (err_actual),
        .arg_cnt      (arg_cnt),
        .res_cnt      (res_cnt),
        .n_cycles     (n_cycles),
        .pass         (pass)
    );

    always #5 clk = ~clk;

    typedef struct {
        int          pend;
        bit          fl;
        int          code;
        logic [31:0] ee;
        logic [31:0] ea;
        logic [32:0] ac;
        logic [32:0] rc;
        logic [32:0] nc;
    } snap_t;

    snap_t       sb[$];
    logic [31:0] mq[$];
    bit          m_fail;
    int          m_code;
    logic [31:0] m_ee, m_ea;
    logic [32:0] m_ac, m_rc, m_nc;
    int          n_chk  = 0;
    int          n_fail = 0;
    int          peak;

    task automatic check(input string tag, input logic [63:0] obs,
                         input logic [63:0] want);
        n_chk++;
        if (obs !== want) begin
            n_fail++;
            $display("FAIL %s: got %0h want %0h", tag, obs, want);
        end
    endtask

    task automatic m_err(input int c, input logic [31:0] e,
                         input logic [31:0] a);
        m_fail = 1'b1;
        m_code = c;
        if (c == 1) begin
            m_ee = e;
            m_ea = a;
        end
    endtask

    task automatic model(input bit r_st, input bit ev, input logic [31:0] e,
                         input bit rv, input logic [31:0] r);
        logic [31:0] h;
        if (r_st) begin
            mq.delete();
            m_fail = 0; m_code = 0; m_ee = 0; m_ea = 0;
            m_ac = 0; m_rc = 0; m_nc = 0;
        end else if (!m_fail) begin
            m_nc++;
            if (ev) m_ac++;
            if (rv) m_rc++;
            if (ev && rv && mq.size() == 0) begin
                if (r !== e) m_err(1, e, r);
            end else begin
                if (rv) begin
                    if (mq.size() == 0) begin
                        m_err(2, 0, 0);
                    end else begin
                        h = mq.pop_front();
                        if (r !== h) m_err(1, h, r);
                    end
                end
                if (ev) begin
                    if (!rv && mq.size() == DEPTH) m_err(3, 0, 0);
                    else mq.push_back(e);
                end
            end
        end
    endtask

    task automatic step(input bit r_st, input bit ev, input logic [31:0] e,
                        input bit rv, input logic [31:0] r);
        snap_t s;
        rst = r_st; exp_vld = ev; exp = e; res_vld = rv; res = r;
        model(r_st, ev, e, rv, r);
        s.pend = mq.size(); s.fl = m_fail; s.code = m_code;
        s.ee = m_ee; s.ea = m_ea; s.ac = m_ac; s.rc = m_rc; s.nc = m_nc;
        sb.push_back(s);
        @(posedge clk);
        #1;
        s = sb.pop_front();
        check("pending",  64'(pending),      64'(s.pend));
        check("fail",     64'(fail),         64'(s.fl));
        check("err_code", 64'(err_code),     64'(s.code));
        check("err_exp",  64'(err_expected), 64'(s.ee));
        check("err_act",  64'(err_actual),   64'(s.ea));
        check("arg_cnt",  64'(arg_cnt),      64'(s.ac));
        check("res_cnt",  64'(res_cnt),      64'(s.rc));
        check("n_cycles", 64'(n_cycles),     64'(s.nc));
        check("pass",     64'(pass), 64'(!s.fl && s.pend == 0));
        if (int'(pending) > peak) peak = int'(pending);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(0, 0, 0, 0, 0);
    endtask

    initial begin
        logic [31:0] vals [5];
        logic [31:0] hv;
        bit          ev, rv;
        logic [31:0] e, r;
        vals[0] = 0; vals[1] = 1; vals[2] = 4; vals[3] = 13; vals[4] = 40;

        // Reset state
        step(1, 0, 0, 0, 0);
        step(1, 1, 8, 1, 8);
        check("rst_pass", 64'(pass), 64'd1);

        // Single push, result two cycles later
        step(0, 1, 3, 0, 0);
        check("one_pend", 64'(pending), 64'd1);
        idle(1);
        step(0, 0, 0, 1, 3);
        check("one_done", 64'(pending), 64'd0);
        check("one_ac",   64'(arg_cnt), 64'd1);
        check("one_rc",   64'(res_cnt), 64'd1);

        // Five back-to-back pushes, results 16 cycles after first push
        peak = 0;
        for (int i = 0; i < 5; i++) step(0, 1, vals[i], 0, 0);
        idle(11);
        for (int i = 0; i < 5; i++) step(0, 0, 0, 1, vals[i]);
        check("peak5",   64'(peak),    64'd5);
        check("end0",    64'(pending), 64'd0);

        // Bypass at empty
        step(0, 1, 7, 1, 7);
        check("byp_pend", 64'(pending), 64'd0);
        check("byp_fail", 64'(fail),    64'd0);

        // Fill to DEPTH, then push+pop together at full
        for (int i = 0; i < DEPTH; i++) step(0, 1, 32'(100 + i), 0, 0);
        check("full_pend", 64'(pending), 64'(DEPTH));
        step(0, 1, 999, 1, 100);
        check("full_pp",   64'(fail),    64'd0);
        while (mq.size() != 0) begin
            hv = mq[0];
            step(0, 0, 0, 1, hv);
        end

        // Random legal traffic
        for (int i = 0; i < 300; i++) begin
            ev = 1'($urandom_range(0, 1));
            rv = 1'($urandom_range(0, 1));
            e  = $urandom;
            if (rv && mq.size() == 0 && !ev) rv = 0;
            if (ev && !rv && mq.size() == DEPTH) ev = 0;
            r = (mq.size() == 0) ? e : mq[0];
            step(0, ev, e, rv, r);
        end
        while (mq.size() != 0) begin
            hv = mq[0];
            step(0, 0, 0, 1, hv);
        end

        // Reset with entries pending, inputs ignored during rst
        for (int i = 0; i < 3; i++) step(0, 1, 32'(i + 1), 0, 0);
        step(1, 1, 5, 1, 5);
        check("rst_pend", 64'(pending),  64'd0);
        check("rst_cyc",  64'(n_cycles), 64'd0);
        step(0, 1, 9, 0, 0);
        step(0, 0, 0, 1, 9);
        check("after_rst", 64'(pass), 64'd1);

        // Mismatch, then counters frozen
        step(0, 1, 5, 0, 0);
        step(0, 0, 0, 1, 6);
        check("mm_code", 64'(err_code),     64'd1);
        check("mm_exp",  64'(err_expected), 64'd5);
        check("mm_act",  64'(err_actual),   64'd6);
        step(0, 1, 11, 0, 0);
        step(0, 0, 0, 1, 12);
        step(0, 0, 0, 1, 12);
        check("mm_keep", 64'(err_code), 64'd1);
        step(1, 0, 0, 0, 0);

        // Unexpected result, later errors ignored
        step(0, 0, 0, 1, 1);
        check("unx_code", 64'(err_code), 64'd2);
        step(0, 1, 2, 1, 3);
        check("unx_keep", 64'(err_code), 64'd2);
        step(1, 0, 0, 0, 0);

        // Overflow on DEPTH+1-th push
        for (int i = 0; i <= DEPTH; i++) step(0, 1, 32'(i), 0, 0);
        check("ovf_code", 64'(err_code), 64'd3);
        check("ovf_pend", 64'(pending),  64'(DEPTH));
        step(1, 0, 0, 0, 0);
        check("final_pass", 64'(pass), 64'd1);

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end

endmodule
